// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D cache physical-memory arbiter.
package cache_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; bit 0 is the I-cache, bit 1 the D-cache.
module rr_arb2
  import cache_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie the requester that was not granted last wins.
    if (req == 2'b11) begin
      gnt = (last_grant == OWN_I) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache, one
// line transaction at a time, with per-requester completion counters.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy,
  output logic [CNT_W-1:0]  i_cnt,
  output logic [CNT_W-1:0]  d_cnt
);

  arb_state_t        state_q, state_d;
  owner_t            last_grant_q, last_grant_d;
  logic              rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic [1:0]        req, gnt;

  assign req = {d_pmem_read | d_pmem_write, i_pmem_read};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_cnt_d      = i_cnt_q;
    d_cnt_d      = d_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt[1]) begin
          state_d      = D_BUSY;
          last_grant_d = OWN_D;
          rd_d         = d_pmem_read;
          wr_d         = d_pmem_write;
          addr_d       = d_pmem_address;
          wdata_d      = d_pmem_wdata;
        end else if (gnt[0]) begin
          state_d      = I_BUSY;
          last_grant_d = OWN_I;
          rd_d         = 1'b1;
          wr_d         = 1'b0;
          addr_d       = i_pmem_address;
          wdata_d      = '0;
        end
      end
      I_BUSY: begin
        if (pmem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          i_cnt_d = i_cnt_q + CNT_W'(1);
        end
      end
      D_BUSY: begin
        if (pmem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          d_cnt_d = d_cnt_q + CNT_W'(1);
          // Write-back lock: the D-cache's refill read must win the next tie.
          if (wr_q) begin
            last_grant_d = OWN_I;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_I;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_cnt_q      <= '0;
      d_cnt_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_cnt_q      <= i_cnt_d;
      d_cnt_q      <= d_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign busy         = busy_q;
  assign i_cnt        = i_cnt_q;
  assign d_cnt        = d_cnt_q;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = pmem_resp && (state_q == I_BUSY);
  assign d_pmem_resp  = pmem_resp && (state_q == D_BUSY);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a transaction-level reference model.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 8;  // narrow counters keep the wrap scenario short

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  logic          busy;
  logic [CW-1:0] i_cnt;
  logic [CW-1:0] d_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_arbiter #(
    .ADDR_W (AW),
    .LINE_W (LW),
    .CNT_W  (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .busy           (busy),
    .i_cnt          (i_cnt),
    .d_cnt          (d_cnt)
  );

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 I, 2 D) and the command it issued.
  int            m_own = 0;
  bit            m_last_d = 1'b0;
  bit            m_wi, m_wd;
  logic          m_rd = 1'b0, m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  logic [CW-1:0] m_icnt = '0, m_dcnt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = 0; m_last_d = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_icnt = '0; m_dcnt = '0;
    end else if (m_own == 0) begin
      m_wi = i_pmem_read;
      m_wd = d_pmem_read | d_pmem_write;
      if (m_wi && m_wd) begin
        m_wd = !m_last_d;
        m_wi = m_last_d;
      end
      if (m_wd) begin
        m_own = 2; m_last_d = 1'b1; m_rd = d_pmem_read; m_wr = d_pmem_write;
        m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
      end else if (m_wi) begin
        m_own = 1; m_last_d = 1'b0; m_rd = 1'b1; m_wr = 1'b0;
        m_addr = i_pmem_address; m_wdata = '0;
      end
    end else if (pmem_resp) begin
      if (m_own == 1) m_icnt = m_icnt + 1'b1;
      else begin
        m_dcnt = m_dcnt + 1'b1;
        if (m_wr) m_last_d = 1'b0;
      end
      m_own = 0; m_rd = 1'b0; m_wr = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_own != 0);
    chk("pmem_read", pmem_read, m_rd);
    chk("pmem_write", pmem_write, m_wr);
    chk("pmem_address", pmem_address, m_addr);
    chk("pmem_wdata", pmem_wdata, m_wdata);
    chk("i_pmem_resp", i_pmem_resp, pmem_resp && (m_own == 1));
    chk("d_pmem_resp", d_pmem_resp, pmem_resp && (m_own == 2));
    chk("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
    chk("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
    chk("i_cnt", i_cnt, m_icnt);
    chk("d_cnt", d_cnt, m_dcnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Memory side: wait for a command, check it, respond after lat cycles, release requester.
  task automatic serve(input int own, input bit wr, input logic [AW-1:0] addr,
                       input logic [LW-1:0] wd, input int lat, input bit perturb,
                       output int waited);
    waited = 0;
    while (!(pmem_read || pmem_write) && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) begin
      tests++;
      fails++;
      $display("FAIL serve_timeout: no command after %0d cycles, expected addr %0h",
               waited, addr);
      return;
    end
    chk("grant_addr", pmem_address, addr);
    chk("grant_write", pmem_write, wr);
    chk("grant_read", pmem_read, !wr);
    if (wr) chk("grant_wdata", pmem_wdata, wd);
    if (perturb) begin
      d_pmem_address = 32'h4444_0000;
      d_pmem_wdata   = {8{32'hDEAD_BEEF}};
    end
    repeat (lat - 1) tick();
    pmem_rdata = {8{addr ^ 32'h5A5A_0000}};
    pmem_resp  = 1'b1;
    #1;
    chk("hold_addr", pmem_address, addr);
    if (wr) chk("hold_wdata", pmem_wdata, wd);
    chk("owner_resp", (own == 1) ? i_pmem_resp : d_pmem_resp, 1'b1);
    chk("other_resp", (own == 1) ? d_pmem_resp : i_pmem_resp, 1'b0);
    chk("owner_rdata", (own == 1) ? i_pmem_rdata : d_pmem_rdata, {8{addr ^ 32'h5A5A_0000}});
    tick();
    pmem_resp = 1'b0;
    if (own == 1) i_pmem_read = 1'b0;
    else begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end
    chk("idle_after_resp", busy, 1'b0);
    chk("cmd_cleared", pmem_read | pmem_write, 1'b0);
  endtask

  initial begin
    int w;
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};

    // Reset state and a lone I read with 3-cycle memory.
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", {i_cnt, d_cnt}, 16'h0);
    rst_n = 1'b1;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    serve(1, 1'b0, 32'h0000_1000, '0, 3, 1'b0, w);
    chk("grant_latency", w, 1);
    chk("i_cnt_after_read", i_cnt, 8'd1);

    // Simultaneous requests at the first arbitration after reset: D first.
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2100;
    serve(2, 1'b0, 32'h0000_2100, '0, 2, 1'b0, w);
    chk("tie_i_waiting", i_cnt, 8'd0);
    serve(1, 1'b0, 32'h0000_1100, '0, 2, 1'b0, w);
    chk("turnaround", w, 1);
    chk("tie_counts", {i_cnt, d_cnt}, {8'd1, 8'd1});

    // Write-back then refill read from D while I stays pending.
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1200;
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2000; d_pmem_wdata = a5;
    serve(2, 1'b1, 32'h0000_2000, a5, 2, 1'b0, w);
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2000;
    serve(2, 1'b0, 32'h0000_2000, '0, 2, 1'b0, w);
    chk("wb_i_still_waiting", i_cnt, 8'd1);
    serve(1, 1'b0, 32'h0000_1200, '0, 1, 1'b0, w);
    chk("wb_counts", {i_cnt, d_cnt}, {8'd2, 8'd3});

    // D changes address/wdata while it owns the port.
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_3000; d_pmem_wdata = {8{32'h1234_5678}};
    serve(2, 1'b1, 32'h0000_3000, {8{32'h1234_5678}}, 3, 1'b1, w);

    // Async reset two cycles into an I read.
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_5000;
    tick();
    chk("rst_txn_started", pmem_read, 1'b1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_read_clear", pmem_read, 1'b0);
    chk("async_busy_clear", busy, 1'b0);
    i_pmem_read = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk("no_resp_in_reset", i_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("no_count_after_abort", i_cnt, 8'd0);

    // Counter wrap with back-to-back single-cycle D reads.
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_6000; pmem_resp = 1'b1;
    for (int n = 0; n < 1000 && d_cnt != 8'hFF; n++) tick();
    d_pmem_read = 1'b0;
    pmem_resp = 1'b0;
    chk("cnt_pre_wrap", d_cnt, 8'hFF);
    d_pmem_read = 1'b1;
    serve(2, 1'b0, 32'h0000_6000, '0, 1, 1'b0, w);
    chk("cnt_wrapped", d_cnt, 8'h00);

    // Stray pmem_resp while idle.
    pmem_resp = 1'b1;
    #1;
    chk("stray_no_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    tick();
    tick();
    pmem_resp = 1'b0;
    chk("stray_busy", busy, 1'b0);
    chk("stray_counts", {i_cnt, d_cnt}, {8'd0, 8'd0});
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
